// File: rtl/norm_rshift_if.sv
// Handshake/data bundle for the normalising right shifter.
// The requester drives start/a/amt; the shifter drives the result fields.
interface norm_rshift_if #(
  parameter int WIDTH = 26,
  parameter int CW    = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [CW-1:0]    amt;
  logic [WIDTH-1:0] out;
  logic             sticky;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;

  modport master (
    output start, a, amt,
    input  out, sticky, count, busy, done
  );

  modport slave (
    input  start, a, amt,
    output out, sticky, count, busy, done
  );
endinterface

// File: rtl/norm_rshift.sv
// Sequential mantissa aligner: shifts right one bit per cycle, collecting a
// sticky bit from everything shifted out, with the distance clamped to WIDTH.
module norm_rshift #(
  parameter int WIDTH = 26,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         reset,
  norm_rshift_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] s_reg;
  logic             sticky_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    rem_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CW-1:0]    amt_eff;

  // Anything at or beyond WIDTH flushes the whole mantissa into sticky.
  assign amt_eff = (bus.amt >= CW'(WIDTH)) ? CW'(WIDTH) : bus.amt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      s_reg      <= '0;
      sticky_reg <= 1'b0;
      count_reg  <= '0;
      rem_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            s_reg      <= bus.a;
            sticky_reg <= 1'b0;
            count_reg  <= '0;
            rem_reg    <= amt_eff;
            if (amt_eff == '0) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= SHIFT;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end

        SHIFT: begin
          s_reg      <= s_reg >> 1;
          sticky_reg <= sticky_reg | s_reg[0];
          count_reg  <= count_reg + CW'(1);
          rem_reg    <= rem_reg - CW'(1);
          // Last shift consumed: result is complete on the next edge.
          if (rem_reg == CW'(1)) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out    = s_reg;
  assign bus.sticky = sticky_reg;
  assign bus.count  = count_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_norm_rshift.sv
// Directed bench for norm_rshift: a vector table of single operations plus
// hand sequences for reset, mid-shift start, abort and back-to-back starts.
module tb_norm_rshift;

  localparam int WIDTH = 26;
  localparam int CW    = 8;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_failed;

  norm_rshift_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  norm_rshift #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [CW-1:0]    amt;
    logic [WIDTH-1:0] exp_out;
    logic             exp_sticky;
    logic [CW-1:0]    exp_count;
    int               exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual != expected) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start for one accept edge and runs until done or the budget
  // expires. inj_cyc > 0 pulses a second (to-be-ignored) start in that cycle.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [CW-1:0] amv,
                        input logic [WIDTH-1:0] eo, input logic es, input logic [CW-1:0] ec,
                        input int el, input int inj_cyc);
    int lat;
    logic busy_seen;
    bus.start = 1'b1;
    bus.a     = av;
    bus.amt   = amv;
    tick();
    bus.start = 1'b0;
    bus.a     = 26'h2AAAAAA;
    bus.amt   = 8'd0;
    lat       = 1;
    busy_seen = bus.busy;
    while (!bus.done && lat < 100) begin
      if (lat == inj_cyc) begin
        bus.start = 1'b1;
        bus.a     = 26'h0000155;
        bus.amt   = 8'd1;
      end
      tick();
      bus.start = 1'b0;
      lat++;
      busy_seen = busy_seen | bus.busy;
    end
    $display("[TB] %s a=%h amt=%0d -> lat=%0d out=%h sticky=%0b count=%0d",
             tag, av, amv, lat, bus.out, bus.sticky, bus.count);
    check({tag, " done_seen"}, bus.done, 1);
    check({tag, " latency"}, lat, el);
    check({tag, " out"}, bus.out, eo);
    check({tag, " sticky"}, bus.sticky, es);
    check({tag, " count"}, bus.count, ec);
    check({tag, " busy_at_done"}, bus.busy, 0);
    if (el == 1) check({tag, " busy_never"}, busy_seen, 0);
    tick();
    check({tag, " done_pulse_1cyc"}, bus.done, 0);
    check({tag, " out_hold"}, bus.out, eo);
    check({tag, " count_hold"}, bus.count, ec);
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;

    vecs[0] = '{26'h2000000, 8'd3,  26'h0400000, 1'b0, 8'd3,  4};
    vecs[1] = '{26'h2000005, 8'd2,  26'h0800001, 1'b1, 8'd2,  3};
    vecs[2] = '{26'h1234567, 8'd0,  26'h1234567, 1'b0, 8'd0,  1};
    vecs[3] = '{26'h0000001, 8'd40, 26'h0000000, 1'b1, 8'd26, 27};
    vecs[4] = '{26'h0000000, 8'd5,  26'h0000000, 1'b0, 8'd5,  6};
    vecs[5] = '{26'h3FFFFFF, 8'd26, 26'h0000000, 1'b1, 8'd26, 27};
    vecs[6] = '{26'h3FFFFFF, 8'd25, 26'h0000001, 1'b1, 8'd25, 26};
    vecs[7] = '{26'h0000080, 8'd7,  26'h0000001, 1'b0, 8'd7,  8};
    vecs[8] = '{26'h0000080, 8'd8,  26'h0000000, 1'b1, 8'd8,  9};
    vecs[9] = '{26'h0000000, 8'd255, 26'h0000000, 1'b0, 8'd26, 27};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.amt   = '0;
    tick();
    tick();
    // Start while reset is held low must be ignored.
    bus.start = 1'b1;
    bus.a     = 26'h3FFFFFF;
    bus.amt   = 8'd4;
    tick();
    bus.start = 1'b0;
    $display("[TB] reset: out=%h sticky=%0b count=%0d busy=%0b done=%0b",
             bus.out, bus.sticky, bus.count, bus.busy, bus.done);
    check("rst out", bus.out, 0);
    check("rst sticky", bus.sticky, 0);
    check("rst count", bus.count, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    reset = 1'b1;
    tick();
    check("post_rst busy", bus.busy, 0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].exp_out,
             vecs[i].exp_sticky, vecs[i].exp_count, vecs[i].exp_lat, 0);

    // Second start during SHIFT cycle 4 must not disturb the running shift.
    run_op("ignore_start", 26'h3FFFFFF, 8'd10, 26'h000FFFF, 1'b1, 8'd10, 11, 4);

    // Reset asserted during SHIFT cycle 5 aborts with no done pulse.
    begin
      logic done_seen;
      bus.start = 1'b1;
      bus.a     = 26'h3FFFFFF;
      bus.amt   = 8'd10;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      check("abort busy_before", bus.busy, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      $display("[TB] abort: out=%h sticky=%0b count=%0d busy=%0b done=%0b",
               bus.out, bus.sticky, bus.count, bus.busy, bus.done);
      check("abort out", bus.out, 0);
      check("abort sticky", bus.sticky, 0);
      check("abort count", bus.count, 0);
      check("abort busy", bus.busy, 0);
      done_seen = bus.done;
      for (int c = 0; c < 12; c++) begin
        tick();
        done_seen = done_seen | bus.done | bus.busy;
      end
      check("abort no_done", done_seen, 0);
      run_op("after_abort", 26'h0000008, 8'd3, 26'h0000001, 1'b0, 8'd3, 4, 0);
    end

    // Start presented in the DONE cycle is accepted immediately.
    begin
      bus.start = 1'b1;
      bus.a     = 26'h0000010;
      bus.amt   = 8'd2;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("b2b first_done", bus.done, 1);
      check("b2b first_out", bus.out, 26'h0000004);
      bus.start = 1'b1;
      bus.a     = 26'h0000003;
      bus.amt   = 8'd1;
      tick();
      bus.start = 1'b0;
      check("b2b accepted_busy", bus.busy, 1);
      check("b2b count_cleared", bus.count, 0);
      tick();
      $display("[TB] b2b: out=%h sticky=%0b count=%0d done=%0b",
               bus.out, bus.sticky, bus.count, bus.done);
      check("b2b second_done", bus.done, 1);
      check("b2b second_out", bus.out, 26'h0000001);
      check("b2b second_sticky", bus.sticky, 1);
      check("b2b second_count", bus.count, 1);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
